rtc_i2c_slave: RTL and testbench

- Upstream front-end of the RTC register block. Converts the external I2C bus (SCL/SDA, open-drain) into the register-access strobes the RTC top consumes: i2c_addr, i2c_data_in, i2c_write_en, i2c_read_en.
- Returns reg_data_out to the bus master on reads.
- Standard 7-bit-address slave with a register pointer that auto-increments, in DS1307 style.

---
 rtl/rtc_i2c_pkg.sv | 23 ++
 rtl/rtc_i2c_slave_i2c_bus_sync.sv | 42 ++++
 rtl/rtc_i2c_slave.sv | 216 +++++++++++++++++++++
 tb/tb_rtc_i2c_slave.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_i2c_pkg.sv
// Shared types and defaults for the RTC I2C slave front-end.
package rtc_i2c_pkg;

  localparam int         DEF_REG_ADDR_W = 4;
  localparam logic [6:0] DEF_SLAVE_ADDR = 7'h68;
  localparam logic       RW_READ        = 1'b1;
  localparam logic       ACK            = 1'b0;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RD_FETCH  = 4'd7,
    ST_RDATA     = 4'd8,
    ST_RD_MACK   = 4'd9,
    ST_WAIT_STOP = 4'd10
  } state_t;

endpackage

// File: rtl/rtc_i2c_slave_i2c_bus_sync.sv
// Pad synchronizer for SCL/SDA with SCL edge and START/STOP condition strobes.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);

  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  // Idle bus level is high, so reset to 1 to avoid phantom edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl_i;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  assign scl_rise_o = scl_s2_q & ~scl_h_q;
  assign scl_fall_o = ~scl_s2_q & scl_h_q;
  assign start_o    = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_o     = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign sda_o      = sda_s2_q;

endmodule

// File: rtl/rtc_i2c_slave.sv
// I2C slave front-end for the RTC register block: 7-bit address, auto-incrementing
// register pointer, one-clk write/read strobes toward the register block.
module rtc_i2c_slave
  import rtc_i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR   = DEF_SLAVE_ADDR,
  parameter int         REG_ADDR_W   = DEF_REG_ADDR_W,
  parameter int         READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [REG_ADDR_W-1:0] i2c_addr,
  output logic [7:0]            i2c_data_in,
  output logic                  i2c_write_en,
  output logic                  i2c_read_en,
  input  logic [7:0]            reg_data_out,
  output logic                  busy,
  output logic [3:0]            dbg_state
);

  localparam logic [3:0] LAT = 4'(READ_LATENCY);

  logic scl_rise, scl_fall, bus_start, bus_stop, sda_s;

  i2c_bus_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl_in),
    .sda_i      (sda_in),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (bus_start),
    .stop_o     (bus_stop),
    .sda_o      (sda_s)
  );

  state_t                state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [6:0]            shift_q, shift_d;
  logic [7:0]            tx_q, tx_d;
  logic [REG_ADDR_W-1:0] ptr_q, ptr_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  busy_q, busy_d;
  logic                  rw_q, rw_d;
  logic [3:0]            lat_q, lat_d;
  logic [7:0]            rx_byte;

  assign rx_byte = {shift_q, sda_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      lat_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
      lat_q     <= lat_d;
    end
  end

  // Strobe protocol: i2c_write_en / i2c_read_en are single-clk pulses, never
  // together; i2c_addr (and i2c_data_in for writes) is valid in that same clk
  // and holds afterwards. There is no back-pressure from the register block.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    lat_d     = lat_q;

    // An issued write always advances the pointer, even if the bus then aborts.
    if (we_q) ptr_d = ptr_q + 1'b1;

    if (bus_start) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (bus_stop) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (state_q == ST_ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_d = ST_ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = ST_WAIT_STOP;
                  busy_d  = 1'b0;
                end
              end else if (state_q == ST_PTR) begin
                ptr_d   = rx_byte[REG_ADDR_W-1:0];
                state_d = ST_PTR_ACK;
              end else begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                wdata_d = rx_byte;
                state_d = ST_WDATA_ACK;
              end
            end
          end
        end
        // bit_cnt 0: waiting for the fall that starts the ACK slot; 1: in the slot.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_oe_d  = 1'b1;
              bit_cnt_d = 4'd1;
              if (state_q == ST_ADDR_ACK && rw_q == RW_READ) begin
                state_d   = ST_RD_FETCH;
                re_d      = 1'b1;
                addr_d    = ptr_q;
                lat_d     = '0;
                bit_cnt_d = '0;
              end
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
            end
          end
        end
        ST_RD_FETCH: begin
          if (lat_q == LAT) begin
            tx_d      = reg_data_out;
            ptr_d     = ptr_q + 1'b1;
            bit_cnt_d = '0;
            state_d   = ST_RDATA;
          end else begin
            lat_d = lat_q + 4'd1;
          end
        end
        // The first fall here is the one closing the preceding ACK slot.
        ST_RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = ST_RD_MACK;
            end else begin
              sda_oe_d  = ~tx_q[7];
              tx_d      = {tx_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        ST_RD_MACK: begin
          if (scl_rise) begin
            if (sda_s == ACK) begin
              state_d = ST_RD_FETCH;
              re_d    = 1'b1;
              addr_d  = ptr_q;
              lat_d   = '0;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe       = sda_oe_q;
  assign i2c_addr     = addr_q;
  assign i2c_data_in  = wdata_q;
  assign i2c_write_en = we_q;
  assign i2c_read_en  = re_q;
  assign busy         = busy_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_rtc_i2c_slave.sv
// Bench for rtc_i2c_slave: bit-banged I2C master, register-block model, strobe scoreboard.
module tb_rtc_i2c_slave;

  localparam time Q = 100ns;

  logic       clk;
  logic       rst;
  logic       scl_m, sda_m;
  logic       sda_line;
  logic       sda_oe;
  logic [3:0] i2c_addr;
  logic [7:0] i2c_data_in;
  logic       i2c_write_en, i2c_read_en;
  logic [7:0] reg_data_out;
  logic       busy;
  logic [3:0] dbg_state;

  logic [7:0]  mem [16];
  logic [12:0] exp_q [$];
  int          n_vec;
  int          n_err;
  int          oe_cycles;
  logic        prev_strobe;

  assign sda_line = sda_m & ~sda_oe;

  rtc_i2c_slave dut (
    .clk          (clk),
    .rst          (rst),
    .scl_in       (scl_m),
    .sda_in       (sda_line),
    .sda_oe       (sda_oe),
    .i2c_addr     (i2c_addr),
    .i2c_data_in  (i2c_data_in),
    .i2c_write_en (i2c_write_en),
    .i2c_read_en  (i2c_read_en),
    .reg_data_out (reg_data_out),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- register block model ----------------
  function automatic logic [7:0] mem_init(input int i);
    case (i)
      0:       mem_init = 8'h3C;
      4:       mem_init = 8'hA5;
      9:       mem_init = 8'h69;
      14:      mem_init = 8'h5E;
      15:      mem_init = 8'hF0;
      default: mem_init = 8'(i * 17);
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= mem_init(i);
      reg_data_out <= 8'h00;
    end else begin
      if (i2c_write_en) mem[i2c_addr] <= i2c_data_in;
      if (i2c_read_en) reg_data_out <= mem[i2c_addr];
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i >= 8 - n; i--) begin
      sda_m = b[i]; #Q;
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0; #Q;
    end
  endtask

  task automatic get_ack(output logic a);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    a = sda_line; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic a);
    send_bits(b, 8);
    get_ack(a);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #Q;
      scl_m = 1'b1; #Q;
      b[i] = sda_line; #Q;
      scl_m = 1'b0;
    end
    #Q;
    sda_m = mack; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
  endtask

  // ---------------- stimulus + monitor ----------------
  initial begin
    logic       a;
    logic [7:0] b;
    int         oe_snap;

    n_vec = 0;
    n_err = 0;
    oe_cycles = 0;
    prev_strobe = 1'b0;
    rst = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;

    fork
      forever begin : monitor
        logic [12:0] got, e;
        @(negedge clk);
        if (sda_oe) oe_cycles++;
        if (i2c_write_en || i2c_read_en) begin
          got = {i2c_write_en, i2c_addr, i2c_write_en ? i2c_data_in : 8'h00};
          n_vec++;
          if (i2c_write_en && i2c_read_en) begin
            n_err++;
            $display("FAIL strobe_excl: got both strobes, required one");
          end else if (prev_strobe) begin
            n_err++;
            $display("FAIL strobe_width: got strobe on consecutive clks, required one clk");
          end else if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL strobe_unexpected: got %h, required none", got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              n_err++;
              $display("FAIL strobe: got {we,addr,data}=%h expected %h", got, e);
            end
          end
        end
        prev_strobe = i2c_write_en | i2c_read_en;
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_sda_oe", 16'(sda_oe), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_strobes", 16'({i2c_write_en, i2c_read_en}), 16'h0);
    check("rst_addr", 16'(i2c_addr), 16'h0);
    check("rst_data", 16'(i2c_data_in), 16'h0);
    check("rst_state", 16'(dbg_state), 16'h0);
    #Q;

    // Reset during the ACK slot of an active write.
    i2c_start();
    write_byte(8'hD0, a); check("rstw_addr_ack", 16'(a), 16'h0);
    write_byte(8'h07, a); check("rstw_ptr_ack", 16'(a), 16'h0);
    exp_q.push_back({1'b1, 4'h7, 8'h99});
    send_bits(8'h99, 8);
    check("rstw_ack_driven", 16'(sda_oe), 16'h1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("rstw_sda_release", 16'(sda_oe), 16'h0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rstw_busy", 16'(busy), 16'h0);
    check("rstw_strobes", 16'({i2c_write_en, i2c_read_en}), 16'h0);
    i2c_stop();
    i2c_start();
    exp_q.push_back({1'b0, 4'h0, 8'h00});
    write_byte(8'hD1, a); check("rstr_addr_ack", 16'(a), 16'h0);
    read_byte(1'b1, b); check("rstr_data_reg0", 16'(b), 16'h003C);
    i2c_stop();

    // Write two registers starting at pointer 2.
    i2c_start();
    write_byte(8'hD0, a); check("wr_addr_ack", 16'(a), 16'h0);
    write_byte(8'h02, a); check("wr_ptr_ack", 16'(a), 16'h0);
    exp_q.push_back({1'b1, 4'h2, 8'h45});
    write_byte(8'h45, a); check("wr_d0_ack", 16'(a), 16'h0);
    exp_q.push_back({1'b1, 4'h3, 8'h12});
    write_byte(8'h12, a); check("wr_d1_ack", 16'(a), 16'h0);
    check("wr_busy", 16'(busy), 16'h1);
    i2c_stop();
    #Q;
    check("wr_busy_stop", 16'(busy), 16'h0);

    // Random read of register 4 via repeated START.
    i2c_start();
    write_byte(8'hD0, a);
    write_byte(8'h04, a);
    i2c_start();
    exp_q.push_back({1'b0, 4'h4, 8'h00});
    write_byte(8'hD1, a); check("rr_addr_ack", 16'(a), 16'h0);
    read_byte(1'b1, b); check("rr_data", 16'(b), 16'h00A5);
    check("rr_nack_release", 16'(sda_oe), 16'h0);
    check("rr_busy", 16'(busy), 16'h1);
    i2c_stop();
    #Q;
    check("rr_busy_stop", 16'(busy), 16'h0);

    // Burst read across the pointer wrap: 14, 15, 0.
    i2c_start();
    write_byte(8'hD0, a);
    write_byte(8'h0E, a);
    i2c_start();
    exp_q.push_back({1'b0, 4'hE, 8'h00});
    exp_q.push_back({1'b0, 4'hF, 8'h00});
    exp_q.push_back({1'b0, 4'h0, 8'h00});
    write_byte(8'hD1, a);
    read_byte(1'b0, b); check("burst_r14", 16'(b), 16'h005E);
    read_byte(1'b0, b); check("burst_r15", 16'(b), 16'h00F0);
    read_byte(1'b1, b); check("burst_r0", 16'(b), 16'h003C);
    i2c_stop();
    i2c_start();
    exp_q.push_back({1'b0, 4'h1, 8'h00});
    write_byte(8'hD1, a);
    read_byte(1'b1, b); check("burst_ptr_after", 16'(b), 16'h0011);
    i2c_stop();

    // Foreign address: no ACK, no strobes, never busy.
    oe_snap = oe_cycles;
    i2c_start();
    write_byte(8'hA0, a); check("mis_addr_nack", 16'(a), 16'h1);
    check("mis_busy", 16'(busy), 16'h0);
    write_byte(8'h55, a); check("mis_data_nack", 16'(a), 16'h1);
    i2c_stop();
    #Q;
    check("mis_sda_oe_cycles", 16'(oe_cycles - oe_snap), 16'h0);

    // STOP in the middle of a data byte.
    i2c_start();
    write_byte(8'hD0, a);
    write_byte(8'h09, a);
    send_bits(8'h5A, 4);
    i2c_stop();
    #Q;
    check("abort_idle", 16'(dbg_state), 16'h0);
    check("abort_busy", 16'(busy), 16'h0);
    i2c_start();
    exp_q.push_back({1'b0, 4'h9, 8'h00});
    write_byte(8'hD1, a);
    read_byte(1'b1, b); check("abort_ptr_read", 16'(b), 16'h0069);
    i2c_stop();

    repeat (20) @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
